lighting_system: RTL and testbench
==================================

Name: lighting_system

Overview:
- Smart-room lighting controller.
- Takes a one-hot time-of-day code, a user light request and a window length. Produces a window-shade opening level, a lamp count and a 16-lamp enable vector.
- Sits between the room sensor/user-input decoders and the lamp/shade driver stage.
- All outputs are registered and updated on the clock.

Parameters:
- NONE. Widths are fixed: 4-bit inputs, 4-bit wshade/lightnum, 16-bit lightstate.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- tcode  input  4  one-hot time code: 0001 night, 0010 morning, 0100 noon, 1000 evening
- ulight  input  4  user-requested lamp count, 0..15
- lenght  input  4  window length / maximum shade opening, 0..15
- wshade  output  4  shade opening level, 0 = closed
- lightnum  output  4  number of lamps on
- lightstate  output  16  lamp enables, thermometer-coded from bit 0

Behaviour:
- Reset (asynchronous, rst=1): wshade=0, lightnum=0, lightstate=0 immediately. Outputs hold 0 while rst is high.
- Normal operation (rst=0): on each rising clk edge, sample tcode/ulight/lenght and register new outputs. Latency is exactly 1 cycle from input change to output. There is no handshake.
- Mode decode (combinational, then registered):
  - tcode=0001 night: wshade=0; lightnum=ulight.
  - tcode=0010 morning: wshade=lenght>>1; lightnum=ulight>>1.
  - tcode=0100 noon: wshade=lenght; lightnum=0.
  - tcode=1000 evening: wshade=lenght>>2; lightnum=ulight-(ulight>>2). This is 4-bit unsigned and never underflows.
  - Any other tcode (0000, multiple bits set): idle. wshade=0, lightnum=0.
- lightstate[i]=1 iff i < lightnum, for i=0..15. lightstate[15] is therefore always 0.
- Shifts are logical and truncating; e.g. 7>>1=3.
- Boundaries:
  - ulight=0 gives lightnum=0 and lightstate=0 in all modes.
  - ulight=15 at night gives lightstate=16'h7FFF.
  - lenght=0 gives wshade=0 in all modes.
- Inputs changing between edges have no effect until the next edge. There is no internal state beyond the output registers.
- Deasserting rst: the first edge afterwards loads the decoded values of the current inputs.

Test Plan:
- Reset: assert rst with tcode=0001, ulight=1010, lenght=1100 -> wshade=0, lightnum=0, lightstate=16'h0000. Check asynchronously, before any clock edge.
- Idle/night: ulight=1010, lenght=1100.
  - tcode=0000 -> all outputs 0.
  - tcode=0001 -> one cycle later: wshade=0, lightnum=10, lightstate=16'h03FF.
- Morning/noon: same inputs.
  - tcode=0010 -> wshade=6, lightnum=5, lightstate=16'h001F.
  - tcode=0100 -> wshade=12, lightnum=0, lightstate=16'h0000.
- Evening/illegal: same inputs.
  - tcode=1000 -> wshade=3, lightnum=8, lightstate=16'h00FF.
  - tcode=0011 -> all outputs 0.
- Extremes:
  - tcode=0001, ulight=1111 -> lightnum=15, lightstate=16'h7FFF.
  - tcode=1000, ulight=0001, lenght=0011 -> lightnum=1, wshade=0, lightstate=16'h0001.
- Reset mid-operation: while in night mode with lightstate=16'h03FF, pulse rst between edges -> outputs clear immediately. After rst falls, outputs return to 16'h03FF on the next edge.

Source files
------------

// File: rtl/lighting_system.sv
`default_nettype none
// ============================================================================
// lighting_system: time-of-day shade/lamp controller with registered outputs.
// Revision 1.0
// ============================================================================
module lighting_system (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  tcode,
  input  logic [3:0]  ulight,
  input  logic [3:0]  lenght,
  output logic [3:0]  wshade,
  output logic [3:0]  lightnum,
  output logic [15:0] lightstate
);

  localparam logic [3:0] C_NIGHT   = 4'b0001;
  localparam logic [3:0] C_MORNING = 4'b0010;
  localparam logic [3:0] C_NOON    = 4'b0100;
  localparam logic [3:0] C_EVENING = 4'b1000;

  logic [3:0]  w_wshade;
  logic [3:0]  w_lightnum;
  logic [15:0] w_lightstate;
  logic [3:0]  r_wshade;
  logic [3:0]  r_lightnum;
  logic [15:0] r_lightstate;

  // Non-one-hot codes fall through to the idle (all-off) default.
  always_comb begin
    w_wshade   = 4'd0;
    w_lightnum = 4'd0;
    case (tcode)
      C_NIGHT: begin
        w_lightnum = ulight;
      end
      C_MORNING: begin
        w_wshade   = lenght >> 1;
        w_lightnum = ulight >> 1;
      end
      C_NOON: begin
        w_wshade   = lenght;
      end
      C_EVENING: begin
        w_wshade   = lenght >> 2;
        w_lightnum = ulight - (ulight >> 2);
      end
      default: begin
        w_wshade   = 4'd0;
        w_lightnum = 4'd0;
      end
    endcase
  end

  // Thermometer decode: lamp i is on when its index is below the lamp count.
  for (genvar i = 0; i < 16; i++) begin : g_therm
    localparam logic [3:0] C_IDX = 4'(i);
    assign w_lightstate[i] = (C_IDX < w_lightnum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wshade     <= 4'd0;
      r_lightnum   <= 4'd0;
      r_lightstate <= 16'd0;
    end else begin
      r_wshade     <= w_wshade;
      r_lightnum   <= w_lightnum;
      r_lightstate <= w_lightstate;
    end
  end

  assign wshade     = r_wshade;
  assign lightnum   = r_lightnum;
  assign lightstate = r_lightstate;

endmodule
`default_nettype wire

// File: tb/tb_lighting_system.sv
`default_nettype none
// Scoreboard bench for lighting_system: driver queues expected outputs from a
// behavioural model, a monitor pops and compares one cycle later.
module tb_lighting_system;

  logic        clk;
  logic        rst;
  logic [3:0]  tcode;
  logic [3:0]  ulight;
  logic [3:0]  lenght;
  logic [3:0]  wshade;
  logic [3:0]  lightnum;
  logic [15:0] lightstate;

  typedef struct {
    int          tag;
    logic [3:0]  ws;
    logic [3:0]  ln;
    logic [15:0] ls;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  lighting_system dut (
    .clk        (clk),
    .rst        (rst),
    .tcode      (tcode),
    .ulight     (ulight),
    .lenght     (lenght),
    .wshade     (wshade),
    .lightnum   (lightnum),
    .lightstate (lightstate)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: room rules stated as plain arithmetic on integers.
  function automatic exp_t model(int tag, int tc, int ul, int len);
    exp_t e;
    int   shade;
    int   lamps;
    shade = 0;
    lamps = 0;
    if (tc == 1) begin
      lamps = ul;
    end else if (tc == 2) begin
      shade = len / 2;
      lamps = ul / 2;
    end else if (tc == 4) begin
      shade = len;
    end else if (tc == 8) begin
      shade = len / 4;
      lamps = ul - ul / 4;
    end
    e.tag = tag;
    e.ws  = 4'(shade);
    e.ln  = 4'(lamps);
    e.ls  = 16'((32'd1 << lamps) - 32'd1);
    return e;
  endfunction

  task automatic chk(string nm, int tag, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s (vector %0d): got %h, expected %h", nm, tag, act, req);
  endtask

  task automatic drive(int tag, logic [3:0] tc, logic [3:0] ul, logic [3:0] len);
    @(negedge clk);
    tcode  = tc;
    ulight = ul;
    lenght = len;
    q.push_back(model(tag, int'(tc), int'(ul), int'(len)));
  endtask

  // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wshade",     e.tag, 16'(wshade),   16'(e.ws));
        chk("lightnum",   e.tag, 16'(lightnum), 16'(e.ln));
        chk("lightstate", e.tag, lightstate,    e.ls);
      end
    end
  end

  initial begin
    logic [3:0] tc_pick [5];
    logic [3:0] tc;
    int         budget;
    rst    = 1'b0;
    tcode  = 4'b0001;
    ulight = 4'b1010;
    lenght = 4'b1100;

    // Asynchronous reset, checked before the first clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset wshade",     -1, 16'(wshade),   16'h0000);
    chk("reset lightnum",   -1, 16'(lightnum), 16'h0000);
    chk("reset lightstate", -1, lightstate,    16'h0000);
    @(negedge clk);
    rst = 1'b0;

    drive(0, 4'b0000, 4'b1010, 4'b1100);
    drive(1, 4'b0001, 4'b1010, 4'b1100);
    drive(2, 4'b0010, 4'b1010, 4'b1100);
    drive(3, 4'b0100, 4'b1010, 4'b1100);
    drive(4, 4'b1000, 4'b1010, 4'b1100);
    drive(5, 4'b0011, 4'b1010, 4'b1100);
    drive(6, 4'b0001, 4'b1111, 4'b1100);
    drive(7, 4'b1000, 4'b0001, 4'b0011);
    drive(8, 4'b0010, 4'b0000, 4'b0000);
    drive(9, 4'b0100, 4'b0000, 4'b1111);

    // Reset pulse between edges while in night mode.
    drive(10, 4'b0001, 4'b1010, 4'b1100);
    @(posedge clk);
    #2;
    chk("pre-pulse lightstate", 10, lightstate, 16'h03FF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("pulse wshade",     11, 16'(wshade),   16'h0000);
    chk("pulse lightnum",   11, 16'(lightnum), 16'h0000);
    chk("pulse lightstate", 11, lightstate,    16'h0000);
    #1 rst = 1'b0;
    q.push_back(model(12, 1, 10, 12));

    tc_pick[0] = 4'b0001;
    tc_pick[1] = 4'b0010;
    tc_pick[2] = 4'b0100;
    tc_pick[3] = 4'b1000;
    tc_pick[4] = 4'b0000;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 5) == 0) tc = 4'($urandom_range(0, 15));
      else                           tc = tc_pick[$urandom_range(0, 3)];
      drive(100 + n, tc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #3;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected responses left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
